// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-port arbiter: data/index widths,
// the write-request record and the starvation state encoding.
package regfile_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        STARVED = 1'b1
    } starve_state_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Small synchronous FIFO buffering debug write requests, with a parallel
// destination compare over every occupied entry.
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  wr_req_t           push_req,
    input  logic              pop,
    output wr_req_t           head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] match_dest,
    output logic              match_hit
);

    wr_req_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: storage has no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // NOTE: default assignment first so the comb block cannot infer a latch.
    always_comb begin
        match_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((((i + DEPTH - int'(rd_ptr)) % DEPTH) < int'(count)) &&
                (mem[i].dest == match_dest))
                match_hit = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the writeback
// stage (fixed priority) and a buffered debug port, with read forwarding.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic [ADDR_W-1:0] dbg_dest,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              rf_write_reg,
    output logic [ADDR_W-1:0] rf_rDest,
    output logic [DATA_W-1:0] rf_writeData,
    input  logic [ADDR_W-1:0] rd_src,
    input  logic [DATA_W-1:0] rd_data_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              pending_hit,
    output logic              stall_req,
    output logic              wb_collision
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    wr_req_t             wb_req, dbg_req, head, issue_req;
    logic                accept, push, pop, issue_valid;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    starve_state_t       state, state_next;
    logic [STARVE_W-1:0] starve_cnt, cnt_next;

    assign wb_req    = '{dest: wb_dest, data: wb_data};
    assign dbg_req   = '{dest: dbg_dest, data: dbg_data};
    assign dbg_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept    = dbg_valid && dbg_ready;

    // WB first, then the buffered head, then a fresh DBG request bypassing the FIFO.
    always_comb begin
        issue_valid = 1'b1;
        issue_req   = dbg_req;
        pop         = 1'b0;
        if (wb_valid) begin
            issue_req = wb_req;
        end else if (!fifo_empty) begin
            issue_req = head;
            pop       = 1'b1;
        end else if (!accept) begin
            issue_valid = 1'b0;
        end
    end

    assign push = accept && !fifo_full && (wb_valid || !fifo_empty);

    regfile_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_req   (dbg_req),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .match_dest (rd_src),
        .match_hit  (pending_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_reg <= 1'b0;
            rf_rDest     <= '0;
            rf_writeData <= '0;
        end else begin
            rf_write_reg <= issue_valid;
            if (issue_valid) begin
                rf_rDest     <= issue_req.dest;
                rf_writeData <= issue_req.data;
            end
        end
    end

    assign rd_data = (rf_write_reg && (rf_rDest == rd_src)) ? rf_writeData : rd_data_in;

    always_comb begin
        cnt_next = starve_cnt;
        if (pop)
            cnt_next = '0;
        else if (wb_valid && !fifo_empty && (starve_cnt != STARVE_W'(STARVE_LIMIT)))
            cnt_next = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= NORMAL;
            starve_cnt   <= '0;
            wb_collision <= 1'b0;
        end else begin
            state        <= state_next;
            starve_cnt   <= cnt_next;
            wb_collision <= stall_req && wb_valid;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            NORMAL:  if (cnt_next == STARVE_W'(STARVE_LIMIT)) state_next = STARVED;
            STARVED: if (pop) state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    always_comb begin
        stall_req = (state == STARVED);
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8x8 register file between two requesters:
  - the pipeline writeback stage (WB), which has fixed priority and never stalls;
  - a debug/loader port (DBG), which uses a valid/ready handshake and is buffered in a small FIFO.
- Drives the register file's write_reg/rDest/writeData from registered outputs.
- Forwards the in-flight write onto the read path.
- Raises a stall request to the pipeline when DBG is starved.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register index width (8 registers)
- FIFO_DEPTH, 2, DBG request buffer entries (power of two, at least 2)
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_req asserts

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  WB write request this cycle
- wb_dest  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB write data
- dbg_valid  in  1  DBG request valid
- dbg_ready  out  1  DBG request can be accepted
- dbg_dest  in  ADDR_W  DBG destination register
- dbg_data  in  DATA_W  DBG write data
- rf_write_reg  out  1  register file write enable (registered)
- rf_rDest  out  ADDR_W  register file write index (registered)
- rf_writeData  out  DATA_W  register file write data (registered)
- rd_src  in  ADDR_W  read index presented to the register file
- rd_data_in  in  DATA_W  srcData from the register file
- rd_data  out  DATA_W  read data with forwarding
- pending_hit  out  1  a buffered DBG write targets rd_src
- stall_req  out  1  pipeline must withhold wb_valid next cycle
- wb_collision  out  1  one-cycle pulse: wb_valid arrived while stall_req=1

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on port reset.
  - Reset values: rf_write_reg=0, rf_rDest=0, rf_writeData=0, stall_req=0, wb_collision=0, starve_cnt=0, FIFO empty, state NORMAL.
  - Reset asserted mid-operation drops all FIFO contents. No write is issued on the cycle after reset.
- Handshake:
  - dbg_ready = (fifo_count < FIFO_DEPTH). It is derived from registered count only.
  - A DBG request is accepted when dbg_valid && dbg_ready.
  - A full FIFO that pops in the same cycle does not accept; dbg_ready stays 0 that cycle.
- Issue priority, evaluated each cycle (a winner appears on rf_* on the next edge, latency 1):
  1. wb_valid → issue WB.
  2. Else FIFO non-empty → pop head, issue it.
  3. Else an accepted DBG request with empty FIFO → issue directly, no buffering.
  4. Else rf_write_reg <= 0; rf_rDest and rf_writeData hold their values.
- A DBG request that is accepted but not issued the same cycle is pushed to the FIFO tail.
- Writes are issued in order: a later issue to the same register overwrites the earlier one. No merging or reordering.
- Forwarding:
  - rd_data = rf_writeData when rf_write_reg && rf_rDest==rd_src; otherwise rd_data_in. This path is combinational.
- pending_hit:
  - Combinational OR over valid FIFO entries of (dest==rd_src).
  - Directly issued requests are never counted.
- Starvation FSM, states NORMAL and STARVED:
  - starve_cnt increments on each cycle where the FIFO is non-empty and WB wins. It clears on any pop and on reset. It saturates at STARVE_LIMIT.
  - NORMAL→STARVED when starve_cnt reaches STARVE_LIMIT. stall_req <= 1 on that edge.
  - STARVED→NORMAL on the edge after a pop. stall_req <= 0 on that edge.
  - In STARVED, a wb_valid still wins. wb_collision pulses 1 on the next cycle and the starvation count is unchanged.
- Counters wrap only via pointer modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W and ADDR_W constants;
  - a write-request struct {dest, data};
  - the state enum {NORMAL, STARVED}.
- One natural sub-module: regfile_wr_fifo, a synchronous FIFO with push/pop/count/full/empty and a parallel dest-compare output for pending_hit.

Test Plan:
- Reset, then wb_valid=1, wb_dest=3, wb_data=8'hA5 for one cycle → next cycle rf_write_reg=1, rf_rDest=3, rf_writeData=8'hA5; following cycle rf_write_reg=0.
- FIFO empty, dbg_valid=1, dbg_dest=5, dbg_data=8'h0F, wb_valid=0 → issued next cycle; FIFO stays empty; dbg_ready stays 1.
- wb_valid held high, three DBG requests presented:
  - two are accepted; dbg_ready=0 after the second; the third waits.
  - after 4 blocked cycles, stall_req=1.
  - drop wb_valid → FIFO head issues; stall_req returns to 0 the next cycle.
- While stall_req=1, drive wb_valid=1 → WB issues and wb_collision pulses for exactly one cycle.
- rf_write_reg=1 with rf_rDest=2 and rf_writeData=8'h55, rd_src=2, rd_data_in=8'h0A → rd_data=8'h55. With rd_src=4 → rd_data=rd_data_in.
- FIFO holding dest=6, rd_src=6 → pending_hit=1. Assert reset for one cycle → FIFO empty, pending_hit=0, rf_write_reg=0, stall_req=0.
